// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle for the branch resolve queue: push, resolve, predictor update and status.
interface branch_resolve_queue_if #(
    parameter int HISTORY_LEN = 10,
    parameter int PTR_W       = 3
);
    logic                   push_valid;
    logic [15:0]            push_pc;
    logic [HISTORY_LEN-1:0] push_history;
    logic                   push_pred;
    logic                   push_ready;
    logic                   resolve_valid;
    logic                   resolve_taken;
    logic                   flush;
    logic                   upd_write_enabled;
    logic                   upd_outcome;
    logic [15:0]            upd_pc;
    logic [HISTORY_LEN-1:0] upd_history;
    logic                   upd_rollback_enabled;
    logic [HISTORY_LEN-1:0] upd_repair_history;
    logic                   mispredict;
    logic [PTR_W:0]         count;
    logic                   full;
    logic                   empty;
    logic                   resolve_error;

    modport master (
        output push_valid, push_pc, push_history, push_pred,
        output resolve_valid, resolve_taken, flush,
        input  push_ready, upd_write_enabled, upd_outcome, upd_pc, upd_history,
        input  upd_rollback_enabled, upd_repair_history, mispredict,
        input  count, full, empty, resolve_error
    );

    modport slave (
        input  push_valid, push_pc, push_history, push_pred,
        input  resolve_valid, resolve_taken, flush,
        output push_ready, upd_write_enabled, upd_outcome, upd_pc, upd_history,
        output upd_rollback_enabled, upd_repair_history, mispredict,
        output count, full, empty, resolve_error
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; pops on resolve and drives predictor training/rollback.
// Latency: update/rollback pulses one cycle after an accepted resolve.
// Backpressure: push_ready = !full; pushes while full are dropped, resolves while empty flag resolve_error.
module branch_resolve_queue #(
    parameter int HISTORY_LEN = 10,
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_queue_if.slave bq
);
    typedef struct packed {
        logic [15:0]            pc;
        logic [HISTORY_LEN-1:0] history;
        logic                   pred;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t         mem [DEPTH];
    entry_t         head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0] count;
    logic [PTR_W:0] count_nxt;
    logic           full_w;
    logic           empty_w;
    logic           push_acc;
    logic           res_acc;
    logic           mis;
    logic           clear;

    assign full_w     = (count == FULL_CNT);
    assign empty_w    = (count == '0);
    assign head_entry = mem[head];
    assign push_acc   = bq.push_valid && !full_w;
    assign res_acc    = bq.resolve_valid && !empty_w;
    assign mis        = res_acc && (bq.resolve_taken != head_entry.pred);
    // Anything younger than a mispredicted or flushed branch is wrong-path.
    assign clear      = mis || bq.flush;

    assign bq.push_ready = !full_w;
    assign bq.full       = full_w;
    assign bq.empty      = empty_w;
    assign bq.count      = count;

    always_comb begin
        count_nxt = count;
        if (push_acc && !res_acc)
            count_nxt = count + (PTR_W+1)'(1);
        else if (res_acc && !push_acc)
            count_nxt = count - (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (res_acc)
                head <= head + PTR_W'(1);
            if (push_acc)
                tail <= tail + PTR_W'(1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc && !clear)
            mem[tail] <= '{pc: bq.push_pc, history: bq.push_history, pred: bq.push_pred};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bq.upd_write_enabled    <= 1'b0;
            bq.upd_outcome          <= 1'b0;
            bq.upd_pc               <= '0;
            bq.upd_history          <= '0;
            bq.upd_rollback_enabled <= 1'b0;
            bq.upd_repair_history   <= '0;
            bq.mispredict           <= 1'b0;
            bq.resolve_error        <= 1'b0;
        end else begin
            bq.upd_write_enabled    <= res_acc;
            bq.upd_rollback_enabled <= mis;
            bq.mispredict           <= mis;
            if (res_acc) begin
                bq.upd_outcome <= bq.resolve_taken;
                bq.upd_pc      <= head_entry.pc;
                bq.upd_history <= head_entry.history;
            end
            // Repaired local history = snapshot shifted with the real outcome.
            if (mis)
                bq.upd_repair_history <= {head_entry.history[HISTORY_LEN-2:0], bq.resolve_taken};
            if (bq.resolve_valid && empty_w)
                bq.resolve_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized + directed bench for branch_resolve_queue against a queue-based reference model with a scoreboard.
module tb_branch_resolve_queue;
    localparam int HL    = 10;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    typedef struct {
        logic [15:0]   pc;
        logic [HL-1:0] hist;
        logic          pred;
    } ent_t;

    typedef struct {
        logic          wr;
        logic          outcome;
        logic [15:0]   pc;
        logic [HL-1:0] hist;
        logic          rb;
        logic [HL-1:0] repair;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    branch_resolve_queue_if #(.HISTORY_LEN(HL), .PTR_W(PTR_W)) bq();

    branch_resolve_queue #(.HISTORY_LEN(HL), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bq    (bq)
    );

    always #5 clk = ~clk;

    ent_t model_q[$];
    exp_t sb[$];
    logic model_err;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, checked on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (sb.size() == 0) begin
                    chk("idle_wr", bq.upd_write_enabled, 0);
                end else begin
                    e = sb.pop_front();
                    chk("upd_write_enabled", bq.upd_write_enabled, e.wr);
                    chk("upd_rollback_enabled", bq.upd_rollback_enabled, e.rb);
                    chk("mispredict", bq.mispredict, e.rb);
                    if (e.wr) begin
                        chk("upd_outcome", bq.upd_outcome, e.outcome);
                        chk("upd_pc", bq.upd_pc, e.pc);
                        chk("upd_history", bq.upd_history, e.hist);
                    end
                    if (e.rb)
                        chk("upd_repair_history", bq.upd_repair_history, e.repair);
                end
            end
        end
    end

    task automatic set_idle();
        bq.push_valid    = 1'b0;
        bq.push_pc       = '0;
        bq.push_history  = '0;
        bq.push_pred     = 1'b0;
        bq.resolve_valid = 1'b0;
        bq.resolve_taken = 1'b0;
        bq.flush         = 1'b0;
    endtask

    task automatic check_status();
        chk("count", bq.count, model_q.size());
        chk("full", bq.full, model_q.size() == DEPTH);
        chk("empty", bq.empty, model_q.size() == 0);
        chk("push_ready", bq.push_ready, model_q.size() != DEPTH);
        chk("resolve_error", bq.resolve_error, model_err);
    endtask

    // Drive one cycle of stimulus, advance the model, record the expected pulse for this edge.
    task automatic cycle(input logic pv, input logic [15:0] pc, input logic [HL-1:0] h, input logic pr,
                         input logic rv, input logic rt, input logic fl);
        exp_t e;
        ent_t hd;
        ent_t ne;
        bit   full_b;
        bit   clr;
        bq.push_valid    = pv;
        bq.push_pc       = pc;
        bq.push_history  = h;
        bq.push_pred     = pr;
        bq.resolve_valid = rv;
        bq.resolve_taken = rt;
        bq.flush         = fl;
        e      = '{default: '0};
        full_b = (model_q.size() == DEPTH);
        clr    = fl;
        if (rv) begin
            if (model_q.size() == 0) begin
                model_err = 1'b1;
            end else begin
                hd        = model_q.pop_front();
                e.wr      = 1'b1;
                e.outcome = rt;
                e.pc      = hd.pc;
                e.hist    = hd.hist;
                if (rt != hd.pred) begin
                    e.rb     = 1'b1;
                    e.repair = {hd.hist[HL-2:0], rt};
                    clr      = 1'b1;
                end
            end
        end
        if (clr) begin
            model_q.delete();
        end else if (pv && !full_b) begin
            ne.pc   = pc;
            ne.hist = h;
            ne.pred = pr;
            model_q.push_back(ne);
        end
        @(posedge clk);
        sb.push_back(e);
        #1;
        check_status();
    endtask

    task automatic push(input logic [15:0] pc, input logic [HL-1:0] h, input logic pr);
        cycle(1'b1, pc, h, pr, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic res(input logic rt);
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b1, rt, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_idle();
        sb.delete();
        model_q.delete();
        model_err = 1'b0;
        #1;
        chk("rst_count", bq.count, 0);
        chk("rst_empty", bq.empty, 1);
        chk("rst_full", bq.full, 0);
        chk("rst_push_ready", bq.push_ready, 1);
        chk("rst_upd_we", bq.upd_write_enabled, 0);
        chk("rst_upd_rb", bq.upd_rollback_enabled, 0);
        chk("rst_mispredict", bq.mispredict, 0);
        chk("rst_upd_pc", bq.upd_pc, 0);
        chk("rst_upd_history", bq.upd_history, 0);
        chk("rst_upd_repair", bq.upd_repair_history, 0);
        chk("rst_upd_outcome", bq.upd_outcome, 0);
        chk("rst_resolve_error", bq.resolve_error, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0]   rpc;
        logic [HL-1:0] rh;
        logic          rpred;
        logic          rtk;
        reset = 1'b1;
        set_idle();
        model_err = 1'b0;
        #2;
        do_reset();

        // Basic in-order training, no mispredicts.
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(16'h0010, 10'h001, 1'b1);
        push(16'h0014, 10'h002, 1'b0);
        push(16'h0018, 10'h003, 1'b1);
        res(1'b1);
        res(1'b0);
        res(1'b1);

        // Fill past capacity, then drain with wraparound.
        for (int i = 0; i < 9; i++)
            push(16'h0100 + 16'(i * 4), 10'(i), 1'(i % 2));
        for (int i = 0; i < 8; i++)
            res(1'(i % 2));

        // Mispredict with a known history snapshot.
        push(16'h0040, 10'h155, 1'b1);
        push(16'h0044, 10'h011, 1'b0);
        push(16'h0048, 10'h022, 1'b1);
        res(1'b0);

        // Concurrent push + resolve, correct then mispredicting.
        push(16'h0200, 10'h0A1, 1'b1);
        push(16'h0204, 10'h0A2, 1'b0);
        cycle(1'b1, 16'h0208, 10'h0A3, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 16'h020C, 10'h0A4, 1'b0, 1'b1, 1'b1, 1'b0);
        push(16'h0210, 10'h0A5, 1'b0);
        res(1'b0);
        res(1'b1);
        push(16'h0300, 10'h3FF, 1'b1);
        res(1'b1);
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // Flush together with a correct resolve, then reset mid-stream.
        for (int i = 0; i < 4; i++)
            push(16'h0400 + 16'(i * 4), 10'(i + 16), 1'b1);
        cycle(1'b1, 16'h0500, 10'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            push(16'h0600 + 16'(i * 4), 10'(i + 32), 1'b0);
        res(1'b0);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rpc   = 16'($urandom);
            rh    = HL'($urandom);
            rpred = 1'($urandom);
            if (model_q.size() != 0 && $urandom_range(0, 7) != 0)
                rtk = model_q[0].pred;
            else
                rtk = 1'($urandom);
            cycle(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, rpc, rh, rpred,
                  ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, rtk,
                  ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 999) == 0)
                do_reset();
        end

        set_idle();
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
